ps2_ascii_decoder: RTL

- Sequential successor to the combinational scan-code-to-ASCII lookup.
- Consumes raw PS/2 set-2 bytes from the PS/2 receiver and tracks make, break (F0) and extended (E0) prefixes, so the downstream logic no longer supplies letter_case.
- Maintains shift and caps-lock state internally.
- Pushes decoded ASCII characters into a parametrised show-ahead FIFO that the game/display logic drains.

---
 rtl/ps2_ascii_decoder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 byte stream to ASCII decoder with make/break/extended prefix tracking,
// internal shift/caps-lock state and a show-ahead character FIFO.
module ps2_ascii_decoder #(
  parameter int unsigned DEPTH       = 8,
  parameter bit          MAP_LETTERS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       rd_en,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       shift_active,
  output logic       caps_lock
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_e;

  state_e     state_q;
  logic       lshift_q;
  logic       rshift_q;
  logic       caps_q;
  logic       caps_held_q;
  logic       shift_q;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          empty_q;
  logic          full_q;
  logic          overflow_q;

  logic       hit_c;
  logic       letter_c;
  logic       digit_c;
  logic [7:0] lower_c;
  logic [7:0] char_c;
  logic       upper_c;
  logic       push_req_c;
  logic       push_c;
  logic       pop_c;
  logic       drop_c;

  // Scan code lookup; lower_c holds the lower-case form for letters.
  always_comb begin
    hit_c    = 1'b1;
    letter_c = 1'b0;
    lower_c  = 8'h00;
    unique case (scan_code)
      8'h45: lower_c = 8'h30;
      8'h16: lower_c = 8'h31;
      8'h1E: lower_c = 8'h32;
      8'h26: lower_c = 8'h33;
      8'h25: lower_c = 8'h34;
      8'h2E: lower_c = 8'h35;
      8'h36: lower_c = 8'h36;
      8'h3D: lower_c = 8'h37;
      8'h3E: lower_c = 8'h38;
      8'h46: lower_c = 8'h39;
      8'h29: lower_c = 8'h20;
      8'h5A: lower_c = 8'h0D;
      8'h1C: begin letter_c = 1'b1; lower_c = 8'h61; end
      8'h32: begin letter_c = 1'b1; lower_c = 8'h62; end
      8'h21: begin letter_c = 1'b1; lower_c = 8'h63; end
      8'h23: begin letter_c = 1'b1; lower_c = 8'h64; end
      8'h24: begin letter_c = 1'b1; lower_c = 8'h65; end
      8'h2B: begin letter_c = 1'b1; lower_c = 8'h66; end
      8'h34: begin letter_c = 1'b1; lower_c = 8'h67; end
      8'h33: begin letter_c = 1'b1; lower_c = 8'h68; end
      8'h43: begin letter_c = 1'b1; lower_c = 8'h69; end
      8'h3B: begin letter_c = 1'b1; lower_c = 8'h6A; end
      8'h42: begin letter_c = 1'b1; lower_c = 8'h6B; end
      8'h4B: begin letter_c = 1'b1; lower_c = 8'h6C; end
      8'h3A: begin letter_c = 1'b1; lower_c = 8'h6D; end
      8'h31: begin letter_c = 1'b1; lower_c = 8'h6E; end
      8'h44: begin letter_c = 1'b1; lower_c = 8'h6F; end
      8'h4D: begin letter_c = 1'b1; lower_c = 8'h70; end
      8'h15: begin letter_c = 1'b1; lower_c = 8'h71; end
      8'h2D: begin letter_c = 1'b1; lower_c = 8'h72; end
      8'h1B: begin letter_c = 1'b1; lower_c = 8'h73; end
      8'h2C: begin letter_c = 1'b1; lower_c = 8'h74; end
      8'h3C: begin letter_c = 1'b1; lower_c = 8'h75; end
      8'h2A: begin letter_c = 1'b1; lower_c = 8'h76; end
      8'h1D: begin letter_c = 1'b1; lower_c = 8'h77; end
      8'h22: begin letter_c = 1'b1; lower_c = 8'h78; end
      8'h35: begin letter_c = 1'b1; lower_c = 8'h79; end
      8'h1A: begin letter_c = 1'b1; lower_c = 8'h7A; end
      default: hit_c = 1'b0;
    endcase
    digit_c = (lower_c >= 8'h30) && (lower_c <= 8'h39);
    // Legacy game map keeps only digits plus o and x.
    if (!MAP_LETTERS && !digit_c && (scan_code != 8'h44) && (scan_code != 8'h22)) begin
      hit_c = 1'b0;
    end
  end

  assign upper_c    = (lshift_q | rshift_q) ^ caps_q;
  assign char_c     = (letter_c && upper_c) ? (lower_c - 8'h20) : lower_c;
  assign push_req_c = scan_valid && (state_q == IDLE) && hit_c;

  // Prefix tracker with shift and caps-lock state; advances only on valid bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      shift_q     <= 1'b0;
    end else if (scan_valid) begin
      case (state_q)
        IDLE: begin
          case (scan_code)
            CODE_BREAK:  state_q <= BREAK;
            CODE_EXT:    state_q <= EXT;
            CODE_LSHIFT: begin lshift_q <= 1'b1; shift_q <= 1'b1; end
            CODE_RSHIFT: begin rshift_q <= 1'b1; shift_q <= 1'b1; end
            CODE_CAPS: begin
              if (!caps_held_q) begin
                caps_q      <= ~caps_q;
                caps_held_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        BREAK: begin
          state_q <= IDLE;
          case (scan_code)
            CODE_LSHIFT: begin lshift_q <= 1'b0; shift_q <= rshift_q; end
            CODE_RSHIFT: begin rshift_q <= 1'b0; shift_q <= lshift_q; end
            CODE_CAPS:   caps_held_q <= 1'b0;
            default: ;
          endcase
        end
        EXT:       state_q <= (scan_code == CODE_BREAK) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // FIFO next-state; head_d precomputes the show-ahead value including a write to an empty slot.
  always_comb begin
    pop_c    = rd_en && !empty_q;
    push_c   = push_req_c && (!full_q || pop_c);
    drop_c   = push_req_c && full_q && !pop_c;
    wr_ptr_d = push_c ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_c ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    if (count_d == '0) begin
      head_d = 8'h00;
    end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
      head_d = char_c;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= 8'h00;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= char_c;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CW'(DEPTH));
      overflow_q <= overflow_q | drop_c;
    end
  end

  assign ascii_out    = head_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign overflow     = overflow_q;
  assign shift_active = shift_q;
  assign caps_lock    = caps_q;

endmodule
